pulse_pc_ctrl: RTL and testbench

Next-PC sequencer for the pulse circuit. Drives `update_pc`/`next_PC` into the pulse PC register and consumes the instruction read from pulse instruction memory at that PC. It also sequences the pulse program: play, wait, single-level loop, jump and halt. Every pulse-program instruction fetch passes through this block.

---
 rtl/pulse_pc_ctrl_if.sv | 22 ++
 rtl/pulse_pc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pulse_pc_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_pc_ctrl_if.sv
// PC-register / instruction-memory bus between the pulse next-PC sequencer and the memory side.
interface pulse_pc_ctrl_if #(
    parameter int unsigned PC_WIDTH   = 11,
    parameter int unsigned WAIT_WIDTH = 12
);
    logic                  update_pc;
    logic [PC_WIDTH-1:0]   next_PC;
    logic [PC_WIDTH-1:0]   PC;
    logic [2:0]            inst_op;
    logic [PC_WIDTH-1:0]   inst_target;
    logic [WAIT_WIDTH-1:0] inst_count;

    modport master (
        output update_pc, next_PC,
        input  PC, inst_op, inst_target, inst_count
    );

    modport slave (
        input  update_pc, next_PC,
        output PC, inst_op, inst_target, inst_count
    );
endinterface

// File: rtl/pulse_pc_ctrl.sv
// Next-PC sequencer for the pulse program: play, wait, single-level loop, jump, halt.
// update_pc/next_PC/play_trig/done are combinational from state and inputs.
module pulse_pc_ctrl #(
    parameter int unsigned PC_WIDTH   = 11,
    parameter int unsigned LOOP_WIDTH = 8,
    parameter int unsigned WAIT_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_pc,
    input  logic                abort,
    pulse_pc_ctrl_if.master     pc_bus,
    output logic                play_trig,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_PLAY       = 3'd0;
    localparam logic [2:0] OP_WAIT       = 3'd1;
    localparam logic [2:0] OP_LOOP_START = 3'd2;
    localparam logic [2:0] OP_LOOP_END   = 3'd3;
    localparam logic [2:0] OP_JUMP       = 3'd4;
    localparam logic [2:0] OP_HALT       = 3'd5;

    state_t                state;
    state_t                state_nxt;
    logic [LOOP_WIDTH-1:0] loop_cnt;
    logic [LOOP_WIDTH-1:0] loop_cnt_nxt;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic [WAIT_WIDTH-1:0] wait_cnt_nxt;
    logic                  err_q;
    logic                  err_nxt;

    logic [PC_WIDTH-1:0]   pc_inc;
    logic [LOOP_WIDTH-1:0] count_lo;

    assign pc_inc   = pc_bus.PC + PC_WIDTH'(1);
    assign count_lo = pc_bus.inst_count[LOOP_WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Loop/wait counters and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loop_cnt <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            loop_cnt <= loop_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state logic; abort outranks everything outside IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                state_nxt = abort ? ST_IDLE : ST_EXEC;
            end
            ST_EXEC: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    case (pc_bus.inst_op)
                        OP_WAIT:  state_nxt = (pc_bus.inst_count != '0) ? ST_WAIT : ST_FETCH;
                        OP_PLAY, OP_LOOP_START, OP_LOOP_END, OP_JUMP:
                                  state_nxt = ST_FETCH;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT: begin
                if (abort)                 state_nxt = ST_IDLE;
                else if (wait_cnt == '0)   state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        pc_bus.update_pc = 1'b0;
        pc_bus.next_PC   = '0;
        play_trig        = 1'b0;
        done             = 1'b0;
        busy             = (state != ST_IDLE);
        err              = err_q;
        loop_cnt_nxt     = loop_cnt;
        wait_cnt_nxt     = wait_cnt;
        err_nxt          = err_q;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_bus.update_pc = 1'b1;
                    pc_bus.next_PC   = start_pc;
                    err_nxt          = 1'b0;
                    loop_cnt_nxt     = '0;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    done         = 1'b1;
                    loop_cnt_nxt = '0;
                    wait_cnt_nxt = '0;
                end
            end
            ST_EXEC: begin
                if (abort) begin
                    done         = 1'b1;
                    loop_cnt_nxt = '0;
                    wait_cnt_nxt = '0;
                end else begin
                    case (pc_bus.inst_op)
                        OP_PLAY: begin
                            play_trig        = 1'b1;
                            pc_bus.update_pc = 1'b1;
                            pc_bus.next_PC   = pc_inc;
                        end
                        OP_WAIT: begin
                            if (pc_bus.inst_count == '0) begin
                                pc_bus.update_pc = 1'b1;
                                pc_bus.next_PC   = pc_inc;
                            end else begin
                                wait_cnt_nxt = pc_bus.inst_count - WAIT_WIDTH'(1);
                            end
                        end
                        OP_LOOP_START: begin
                            loop_cnt_nxt     = (count_lo == '0) ? LOOP_WIDTH'(1) : count_lo;
                            pc_bus.update_pc = 1'b1;
                            pc_bus.next_PC   = pc_inc;
                        end
                        OP_LOOP_END: begin
                            pc_bus.update_pc = 1'b1;
                            if (loop_cnt > LOOP_WIDTH'(1)) begin
                                loop_cnt_nxt   = loop_cnt - LOOP_WIDTH'(1);
                                pc_bus.next_PC = pc_bus.inst_target;
                            end else begin
                                loop_cnt_nxt   = '0;
                                pc_bus.next_PC = pc_inc;
                            end
                        end
                        OP_JUMP: begin
                            pc_bus.update_pc = 1'b1;
                            pc_bus.next_PC   = pc_bus.inst_target;
                        end
                        OP_HALT: begin
                            done = 1'b1;
                        end
                        default: begin
                            done    = 1'b1;
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    done         = 1'b1;
                    loop_cnt_nxt = '0;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == '0) begin
                    pc_bus.update_pc = 1'b1;
                    pc_bus.next_PC   = pc_inc;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_WIDTH'(1);
                end
            end
            default: ;
        endcase

        // Reset forces every output low even before the state register clears
        if (!rst_n) begin
            pc_bus.update_pc = 1'b0;
            pc_bus.next_PC   = '0;
            play_trig        = 1'b0;
            done             = 1'b0;
            busy             = 1'b0;
            err              = 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_pc_ctrl.sv
// Bench for pulse_pc_ctrl: instruction-level program model produces the expected
// per-cycle outputs; directed programs plus randomized programs with abort/reset.
module tb_pulse_pc_ctrl;

    localparam int CAP = 300;

    typedef struct packed {
        logic        upd;
        logic [10:0] npc;
        logic        trig;
        logic        done;
        logic        busy;
        logic        err;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] start_pc = '0;
    logic        abort = 1'b0;
    logic        play_trig, busy, done, err;

    pulse_pc_ctrl_if #(.PC_WIDTH(11), .WAIT_WIDTH(12)) bus ();

    pulse_pc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_pc  (start_pc),
        .abort     (abort),
        .pc_bus    (bus),
        .play_trig (play_trig),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Program memory and PC register on the slave side of the bus
    logic [2:0]  m_op  [2048];
    logic [10:0] m_tgt [2048];
    logic [11:0] m_cnt [2048];
    logic [10:0] pc_reg = '0;
    logic [2:0]  op_q = 3'd5;
    logic [10:0] tgt_q = '0;
    logic [11:0] cnt_q = '0;

    always @(posedge clk) begin
        if (bus.update_pc) pc_reg <= bus.next_PC;
        op_q  <= m_op[pc_reg];
        tgt_q <= m_tgt[pc_reg];
        cnt_q <= m_cnt[pc_reg];
    end

    assign bus.PC          = pc_reg;
    assign bus.inst_op     = op_q;
    assign bus.inst_target = tgt_q;
    assign bus.inst_count  = cnt_q;

    int   n_chk = 0;
    int   n_pass = 0;
    obs_t exp_q[$];
    obs_t dut_q[$];
    int   cyc;
    int   rst_at_g;
    int   abt_at_g;
    logic m_err = 1'b0;

    function automatic obs_t mk(input logic u, input logic [10:0] p, input logic t,
                                input logic d, input logic b, input logic e);
        obs_t o;
        o.upd = u; o.npc = p; o.trig = t; o.done = d; o.busy = b; o.err = e;
        return o;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s @%0d: got %0h, want %0h", name, idx, got, want);
    endtask

    // One program cycle: reset or abort at this cycle replaces the normal record and ends the run
    task automatic step(input obs_t rec, output bit hit);
        hit = 1'b1;
        if (cyc == rst_at_g) begin
            exp_q.push_back('0);
            m_err = 1'b0;
        end else if (cyc == abt_at_g) begin
            exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b1, m_err));
        end else begin
            exp_q.push_back(rec);
            hit = 1'b0;
        end
        cyc++;
    endtask

    // Interpret the program instruction by instruction into expected cycle records
    task automatic gen(input logic [10:0] spc, input int abort_at, input int reset_at);
        logic [10:0] pc, tgt;
        int          loops, n;
        bit          fin, hit;
        exp_q.delete();
        rst_at_g = reset_at;
        abt_at_g = (abort_at > 0 && abort_at < CAP) ? abort_at : CAP;
        exp_q.push_back(mk(1'b1, spc, 1'b0, 1'b0, 1'b0, m_err));
        m_err = 1'b0; loops = 0; pc = spc; cyc = 1; fin = 1'b0; hit = 1'b0;
        while (!fin) begin
            step(mk(1'b0, '0, 1'b0, 1'b0, 1'b1, m_err), hit);
            if (hit) break;
            n   = int'(m_cnt[pc]);
            tgt = m_tgt[pc];
            case (m_op[pc])
                3'd0: begin
                    step(mk(1'b1, pc + 11'd1, 1'b1, 1'b0, 1'b1, m_err), hit);
                    pc = pc + 11'd1;
                end
                3'd1: begin
                    if (n == 0) begin
                        step(mk(1'b1, pc + 11'd1, 1'b0, 1'b0, 1'b1, m_err), hit);
                    end else begin
                        step(mk(1'b0, '0, 1'b0, 1'b0, 1'b1, m_err), hit);
                        for (int w = 1; w <= n && !hit; w++)
                            step(mk(w == n, (w == n) ? pc + 11'd1 : 11'd0, 1'b0, 1'b0, 1'b1, m_err), hit);
                    end
                    pc = pc + 11'd1;
                end
                3'd2: begin
                    step(mk(1'b1, pc + 11'd1, 1'b0, 1'b0, 1'b1, m_err), hit);
                    loops = ((n % 256) == 0) ? 1 : (n % 256);
                    pc = pc + 11'd1;
                end
                3'd3: begin
                    if (loops > 1) begin
                        step(mk(1'b1, tgt, 1'b0, 1'b0, 1'b1, m_err), hit);
                        loops--; pc = tgt;
                    end else begin
                        step(mk(1'b1, pc + 11'd1, 1'b0, 1'b0, 1'b1, m_err), hit);
                        loops = 0; pc = pc + 11'd1;
                    end
                end
                3'd4: begin
                    step(mk(1'b1, tgt, 1'b0, 1'b0, 1'b1, m_err), hit);
                    pc = tgt;
                end
                3'd5: begin
                    step(mk(1'b0, '0, 1'b0, 1'b1, 1'b1, m_err), hit);
                    fin = 1'b1;
                end
                default: begin
                    step(mk(1'b0, '0, 1'b0, 1'b1, 1'b1, m_err), hit);
                    if (!hit) m_err = 1'b1;
                    fin = 1'b1;
                end
            endcase
            if (hit) fin = 1'b1;
        end
        if (cyc == rst_at_g) begin
            exp_q.push_back('0);
            m_err = 1'b0;
        end else begin
            exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, 1'b0, m_err));
        end
    endtask

    // Drive one program run and compare every cycle against the model
    task automatic run(input logic [10:0] spc, input int abort_at, input int reset_at, input bit noise);
        obs_t got;
        int   last;
        gen(spc, abort_at, reset_at);
        dut_q.delete();
        last = exp_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            start    = (i == 0) || (noise && i > 0 && exp_q[i].busy && $urandom_range(0, 3) == 0);
            start_pc = (i == 0) ? spc : 11'($urandom);
            abort    = (i == abt_at_g) || (noise && (i == 0 || i == last) && $urandom_range(0, 1) == 1);
            rst_n    = (i != reset_at);
            #1;
            got = mk(bus.update_pc, bus.next_PC, play_trig, done, busy, err);
            dut_q.push_back(got);
            chk("cycle", i, 32'(got), 32'(exp_q[i]));
        end
    endtask

    function automatic int first_idx(input int kind, input int from);
        for (int i = from; i < dut_q.size(); i++) begin
            if (kind == 0 && dut_q[i].trig) return i;
            if (kind == 1 && dut_q[i].upd)  return i;
            if (kind == 2 && dut_q[i].done) return i;
        end
        return -1;
    endfunction

    function automatic int n_trig();
        int c = 0;
        foreach (dut_q[i]) if (dut_q[i].trig) c++;
        return c;
    endfunction

    function automatic int n_upd_to(input logic [10:0] a);
        int c = 0;
        foreach (dut_q[i]) if (dut_q[i].upd && dut_q[i].npc == a) c++;
        return c;
    endfunction

    task automatic put(input logic [10:0] a, input logic [2:0] op, input logic [10:0] t, input logic [11:0] c);
        m_op[a] = op; m_tgt[a] = t; m_cnt[a] = c;
    endtask

    initial begin
        obs_t        o;
        logic [10:0] base, a;
        int          sel, ab, rs, li;
        for (int i = 0; i < 2048; i++) put(11'(i), 3'd5, '0, '0);

        repeat (3) @(negedge clk);
        #1;
        o = mk(bus.update_pc, bus.next_PC, play_trig, done, busy, err);
        chk("reset_outputs", 0, 32'(o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        o = mk(bus.update_pc, bus.next_PC, play_trig, done, busy, err);
        chk("idle_after_reset", 0, 32'(o), 32'h0);

        // Straight line PLAY, PLAY, HALT
        put(11'h010, 3'd0, '0, '0); put(11'h011, 3'd0, '0, '0); put(11'h012, 3'd5, '0, '0);
        run(11'h010, -1, -1, 1'b0);
        chk("line_trig1", 0, 32'(first_idx(0, 0)), 32'd2);
        chk("line_trig2", 0, 32'(first_idx(0, 3)), 32'd4);
        chk("line_npc1", 2, 32'(dut_q[2].npc), 32'h011);
        chk("line_npc2", 4, 32'(dut_q[4].npc), 32'h012);
        chk("line_done", 0, 32'(first_idx(2, 0)), 32'd6);
        chk("line_busy_low", 7, 32'(dut_q[7].busy), 32'd0);

        // Loop of 3
        put(11'h020, 3'd2, '0, 12'd3); put(11'h021, 3'd0, '0, '0);
        put(11'h022, 3'd3, 11'h021, '0); put(11'h023, 3'd5, '0, '0);
        run(11'h020, -1, -1, 1'b0);
        chk("loop_trigs", 0, 32'(n_trig()), 32'd3);
        chk("loop_to_body", 0, 32'(n_upd_to(11'h021)), 32'd3);
        chk("loop_exit", 0, 32'(n_upd_to(11'h023)), 32'd1);

        // WAIT 5 then PLAY
        put(11'h100, 3'd1, '0, 12'd5); put(11'h101, 3'd0, '0, '0); put(11'h102, 3'd5, '0, '0);
        run(11'h100, -1, -1, 1'b0);
        chk("wait5_upd", 0, 32'(first_idx(1, 1)), 32'd7);
        chk("wait5_trig", 0, 32'(first_idx(0, 0)), 32'd9);

        // WAIT 0 is a NOP
        put(11'h140, 3'd1, '0, 12'd0); put(11'h141, 3'd0, '0, '0); put(11'h142, 3'd5, '0, '0);
        run(11'h140, -1, -1, 1'b0);
        chk("wait0_npc", 2, 32'(dut_q[2].npc), 32'h141);
        chk("wait0_trig", 0, 32'(first_idx(0, 0)), 32'd4);

        // PC wrap and jump
        put(11'h7FF, 3'd0, '0, '0);
        run(11'h7FF, -1, -1, 1'b0);
        chk("wrap_upd", 2, 32'(dut_q[2].upd), 32'd1);
        chk("wrap_npc", 2, 32'(dut_q[2].npc), 32'h000);
        put(11'h200, 3'd4, 11'h123, '0);
        run(11'h200, -1, -1, 1'b0);
        chk("jump_npc", 2, 32'(dut_q[2].npc), 32'h123);
        chk("jump_no_trig", 0, 32'(n_trig()), 32'd0);

        // Illegal opcode sets sticky err; next start clears it
        put(11'h300, 3'd6, '0, '0);
        run(11'h300, -1, -1, 1'b0);
        chk("ill_done", 2, 32'(dut_q[2].done), 32'd1);
        chk("ill_err", 3, 32'(dut_q[3].err), 32'd1);
        run(11'h010, -1, -1, 1'b0);
        chk("err_held", 0, 32'(dut_q[0].err), 32'd1);
        chk("err_cleared", 1, 32'(dut_q[1].err), 32'd0);

        // Abort on third WAIT cycle of WAIT 10
        put(11'h400, 3'd1, '0, 12'd10);
        run(11'h400, 5, -1, 1'b0);
        chk("abort_done", 5, 32'(dut_q[5].done), 32'd1);
        chk("abort_no_upd", 5, 32'(dut_q[5].upd), 32'd0);
        chk("abort_idle", 6, 32'(dut_q[6].busy), 32'd0);

        // Reset mid-loop, then a full loop
        run(11'h020, -1, 6, 1'b0);
        chk("rst_all_low", 6, 32'(dut_q[6]), 32'h0);
        run(11'h020, -1, -1, 1'b0);
        chk("loop_after_rst", 0, 32'(n_trig()), 32'd3);

        // Random programs
        for (int r = 0; r < 60; r++) begin
            base = 11'($urandom);
            for (int k = 0; k < 24; k++) begin
                a   = base + 11'(k);
                sel = $urandom_range(0, 15);
                m_tgt[a] = base + 11'($urandom_range(0, 23));
                m_cnt[a] = 12'($urandom_range(0, 6));
                if (sel <= 5)       m_op[a] = 3'd0;
                else if (sel <= 7)  m_op[a] = 3'd1;
                else if (sel <= 9) begin
                    m_op[a] = 3'd2;
                    li = $urandom_range(0, 3);
                    m_cnt[a] = {4'($urandom_range(0, 15)), 8'(li)};
                end
                else if (sel <= 11) m_op[a] = 3'd3;
                else if (sel == 12) m_op[a] = 3'd4;
                else if (sel == 13) m_op[a] = 3'd5;
                else if (sel == 14) m_op[a] = 3'd6;
                else                m_op[a] = 3'd7;
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : -1;
            rs = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 60) : -1;
            run(base, ab, rs, 1'b1);
        end

        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
